bcd_serial_add_seq: RTL and testbench
=====================================

// Module: bcd_serial_add_seq
// PURPOSE
// - Bit-serial packed-BCD adder controller. Time-shares one 1-bit full-adder cell (fadder1) across all bits,
//   including the +6 decimal correction pass.
// - Accepts two packed-BCD operands plus carry-in over a valid/ready handshake.
// - Sequences the cell LSB-first, one digit at a time, and returns the BCD sum and decimal carry-out.
// - Sits between operand registers and the display/result path of the 8-bit BCD adder design.
// PARAMETERS
// - DIGITS   2   number of BCD digits per operand; operand width W = 4*DIGITS
// PORTS
// - clk        in   1   single clock; all state changes on rising edge
// - rst_n      in   1   asynchronous, active-low reset
// - in_valid   in   1   operands presented
// - in_ready   out  1   controller idle and able to accept
// - a_i        in   W   packed-BCD operand A, digit 0 in [3:0]
// - b_i        in   W   packed-BCD operand B
// - cin_i      in   1   decimal carry-in
// - out_valid  out  1   result available
// - out_ready  in   1   consumer takes result
// - sum_o      out  W   packed-BCD sum
// - cout_o     out  1   decimal carry-out of the top digit
// - err_o      out  1   at least one captured input nibble was >9; qualified by out_valid
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, out_valid=0, sum_o=0, cout_o=0, err_o=0; all shift/carry/counter regs cleared.
// - Reset mid-operation aborts immediately; no partial result is ever flagged valid.
// - FSM states: IDLE, ADD, CHK, COR, DONE.
// - IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: capture a_i, b_i; carry reg <= cin_i; err <= any nibble of a_i/b_i >9.
//   - Digit index <= 0, bit index <= 0; go to ADD.
// - ADD (4 cycles/digit), bit i of current digit:
//   - s = fadder1(a_bit, b_bit, carry); carry <= cell cout.
//   - s is shifted into a 4-bit digit reg.
//   - After bit 3, c4 = cell cout of bit 3; go to CHK.
// - CHK (1 cycle): need = c4 | (digit > 9). Latch need; clear carry reg to 0; go to COR.
// - COR (4 cycles/digit):
//   - The cell adds digit bit i + corr bit i, with corr = need ? 4'b0110 : 4'b0000.
//   - The carry chain is internal to the pass; its final carry-out is discarded.
//   - Corrected bits shift into the result reg.
//   - After bit 3: carry reg <= need (the decimal carry into the next digit).
//   - If digit index = DIGITS-1, go to DONE; else increment digit index and go to ADD.
//   - The correction pass always runs, so latency is fixed.
// - DONE:
//   - out_valid=1; sum_o/cout_o/err_o stable while out_valid=1 and out_ready=0.
//   - On out_ready: return to IDLE and clear out_valid the next cycle.
// - Latency: out_valid rises exactly 9*DIGITS rising edges after the accepting edge (18 for DIGITS=2).
// - Throughput: one operation per 9*DIGITS+2 cycles with out_ready held high.
// - in_ready=0 in every state except IDLE; inputs are ignored while busy (no queueing).
// - Invalid BCD input:
//   - The algorithm runs unchanged; the result is deterministic per the rules above.
//   - err_o=1 is reported with that result.
// - Wrap-around: 99+99+1 = 199 gives sum_o=8'h99, cout_o=1. Overflow beyond DIGITS digits exists only as cout_o.
// - The cell is the sole adder: no '+' operator on operand data in the controller (counters excepted).
// STRUCTURE
// - Shared package bcd_pkg:
//   - FSM state enum (3-bit localparams).
//   - BCD_MAX=4'd9 and BCD_CORR=4'b0110.
//   - digit/bit counter width function clog2(DIGITS).
// - One sub-module: a single instance of the existing fadder1 (a, b, cin -> sum, cout).
//   Operand mux selects (a_bit, b_bit) in ADD or (digit_bit, corr_bit) in COR.
// TESTING
// - 8'h45+8'h23, cin=0 -> sum_o=8'h68, cout_o=0, err_o=0; out_valid exactly 18 cycles after accept.
// - 8'h99+8'h99, cin=1 -> sum_o=8'h99, cout_o=1 (double correction plus carry chaining).
// - 8'h08+8'h09, cin=0 -> 8'h17 (low digit >9 correction); 8'h50+8'h50 -> 8'h00, cout_o=1 (c4-free high-digit wrap).
// - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; a new in_valid pulse is ignored.
//   Then out_ready=1 -> IDLE; the next operation is accepted.
// - Drop rst_n during COR of digit 1 -> out_valid=0, in_ready=1 asynchronously.
//   After release, 8'h12+8'h34 -> 8'h46.
// - 8'h0A+8'h01 -> err_o=1 with out_valid; back-to-back random valid-BCD pairs vs. decimal reference model, 500 ops.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the bit-serial packed-BCD adder controller.
package bcd_pkg;

    // Controller states, encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_CHK  = 3'd2,
        ST_COR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Largest legal BCD digit value.
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Decimal correction constant added when a digit overflows past 9.
    localparam logic [3:0] BCD_CORR = 4'b0110;

    // Counter width for an index over n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fadder1.sv
// Single-bit full adder cell; the only arithmetic element on operand data.
module fadder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bcd_serial_add_seq.sv
// Bit-serial packed-BCD adder controller. One full-adder cell is time-shared
// across the binary add of each digit and its +6 decimal correction pass.
// Each digit costs 4 add cycles, 1 check cycle and 4 correction cycles.
module bcd_serial_add_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a_i,
    input  logic [4*DIGITS-1:0] b_i,
    input  logic                cin_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum_o,
    output logic                cout_o,
    output logic                err_o
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = clog2(DIGITS);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic [3:0]    digit;
    logic          carry;
    logic          need;
    logic          err_cap;
    logic [1:0]    bit_idx;
    logic [DW-1:0] dig_idx;
    logic          in_err;
    logic          cell_a;
    logic          cell_b;
    logic          cell_s;
    logic          cell_c;

    // Flag any operand nibble outside 0..9 at capture time.
    always_comb begin
        in_err = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if ((a_i[4*d +: 4] > BCD_MAX) || (b_i[4*d +: 4] > BCD_MAX)) begin
                in_err = 1'b1;
            end
        end
    end

    // Feed the cell with operand bits while adding, or with the partial digit and correction bits while correcting.
    always_comb begin
        cell_a = 1'b0;
        cell_b = 1'b0;
        if (state == ST_ADD) begin
            cell_a = a_sh[0];
            cell_b = b_sh[0];
        end else if (state == ST_COR) begin
            cell_a = digit[0];
            cell_b = need & BCD_CORR[bit_idx];
        end
    end

    fadder1 u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .cin  (carry),
        .sum  (cell_s),
        .cout (cell_c)
    );

    // Controller FSM and serial datapath; outputs are registered and only change on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            digit     <= '0;
            carry     <= 1'b0;
            need      <= 1'b0;
            err_cap   <= 1'b0;
            bit_idx   <= '0;
            dig_idx   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_o     <= '0;
            cout_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a_i;
                        b_sh     <= b_i;
                        carry    <= cin_i;
                        err_cap  <= in_err;
                        dig_idx  <= '0;
                        bit_idx  <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    digit   <= {cell_s, digit[3:1]};
                    carry   <= cell_c;
                    bit_idx <= bit_idx + 2'd1;
                    if (bit_idx == 2'd3) begin
                        state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    // carry holds the binary carry out of bit 3 of this digit
                    need  <= carry | (digit > BCD_MAX);
                    carry <= 1'b0;
                    state <= ST_COR;
                end
                ST_COR: begin
                    res_sh  <= {cell_s, res_sh[W-1:1]};
                    digit   <= digit >> 1;
                    bit_idx <= bit_idx + 2'd1;
                    if (bit_idx == 2'd3) begin
                        // the correction pass carry-out is dropped; the decimal carry is 'need'
                        carry <= need;
                        if (dig_idx == LAST_DIGIT) begin
                            out_valid <= 1'b1;
                            sum_o     <= {cell_s, res_sh[W-1:1]};
                            cout_o    <= need;
                            err_o     <= err_cap;
                            state     <= ST_DONE;
                        end else begin
                            dig_idx <= dig_idx + DW'(1);
                            state   <= ST_ADD;
                        end
                    end else begin
                        carry <= cell_c;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_seq.sv
// Self-checking bench for bcd_serial_add_seq with directed vectors and a decimal reference for random ops.
module tb_bcd_serial_add_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_o;
    logic       cout_o;
    logic       err_o;

    int check_count;
    int pass_count;

    bcd_serial_add_seq #(.DIGITS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .err_o     (err_o)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one operation, check accept and latency, then check the result (left waiting in DONE).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input logic [7:0] exp_sum, input logic exp_cout, input logic exp_err,
                                 input string tag);
        int lat;
        @(negedge clk);
        checkOutput({tag, " in_ready before accept"}, in_ready, 1'b1);
        a_i      = a;
        b_i      = b;
        cin_i    = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput({tag, " in_ready busy"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checkOutput({tag, " latency"}, lat, 18);
        checkOutput({tag, " sum"}, sum_o, exp_sum);
        checkOutput({tag, " cout"}, cout_o, exp_cout);
        checkOutput({tag, " err"}, err_o, exp_err);
    endtask

    // Take the result and confirm the controller returns to idle.
    task automatic consumeResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid cleared"}, out_valid, 1'b0);
        checkOutput({tag, " in_ready back"}, in_ready, 1'b1);
    endtask

    initial begin
        int ra;
        int rb;
        int rc;
        int total;
        int seen;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] es;
        logic [3:0] tens;
        logic [3:0] ones;

        check_count = 0;
        pass_count  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;

        // Reset values.
        #12;
        checkOutput("reset in_ready", in_ready, 1'b1);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset sum", sum_o, 8'h00);
        checkOutput("reset cout", cout_o, 1'b0);
        checkOutput("reset err", err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        applyStimulus(8'h45, 8'h23, 1'b0, 8'h68, 1'b0, 1'b0, "45+23");
        consumeResult("45+23");
        applyStimulus(8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0, "99+99+1");
        consumeResult("99+99+1");
        applyStimulus(8'h08, 8'h09, 1'b0, 8'h17, 1'b0, 1'b0, "08+09");
        consumeResult("08+09");
        applyStimulus(8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, "50+50");
        consumeResult("50+50");

        // Hold the result for 10 cycles and poke in_valid while busy.
        applyStimulus(8'h37, 8'h48, 1'b1, 8'h86, 1'b0, 1'b0, "hold 37+48+1");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a_i      = 8'h11;
                b_i      = 8'h11;
                cin_i    = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checkOutput("hold out_valid", out_valid, 1'b1);
            checkOutput("hold in_ready", in_ready, 1'b0);
            checkOutput("hold sum", sum_o, 8'h86);
            checkOutput("hold cout", cout_o, 1'b0);
        end
        in_valid = 1'b0;
        consumeResult("hold");
        applyStimulus(8'h21, 8'h30, 1'b0, 8'h51, 1'b0, 1'b0, "after hold 21+30");
        consumeResult("after hold");

        // Reset during the correction pass of digit 1.
        @(negedge clk);
        a_i      = 8'h77;
        b_i      = 8'h66;
        cin_i    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", out_valid, 1'b0);
        checkOutput("midreset in_ready", in_ready, 1'b1);
        checkOutput("midreset sum", sum_o, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
            end
        end
        checkOutput("midreset no stale valid", seen, 0);
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "12+34");
        consumeResult("12+34");

        // Invalid BCD digit: A+1 = 11 -> corrected to 1 with carry, so 0A+01 gives 11.
        applyStimulus(8'h0A, 8'h01, 1'b0, 8'h11, 1'b0, 1'b1, "0A+01");
        consumeResult("0A+01");

        // Random valid BCD operations against a decimal reference.
        for (int n = 0; n < 500; n++) begin
            ra = 10 * $urandom_range(0, 9) + $urandom_range(0, 9);
            rb = 10 * $urandom_range(0, 9) + $urandom_range(0, 9);
            rc = $urandom_range(0, 1);
            ea = {4'(ra / 10), 4'(ra % 10)};
            eb = {4'(rb / 10), 4'(rb % 10)};
            total = ra + rb + rc;
            tens = 4'((total % 100) / 10);
            ones = 4'(total % 10);
            es = {tens, ones};
            applyStimulus(ea, eb, rc[0], es, (total >= 100), 1'b0, "random");
            consumeResult("random");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
